exibe_sequencia: RTL and testbench

Sequence presenter for the memory game: on request, reads the stored sequence from address 0 up to a given last address and shows each element on the LEDs for a fixed on-time followed by a fixed off-time. It is the output-side counterpart of the game control unit, which reads the same memory to check player moves. The control unit starts it at the beginning of each round and waits for `fim` before accepting moves.

---
 rtl/exibe_sequencia_pkg.sv | 24 ++
 rtl/exibe_sequencia_if.sv | 25 ++
 rtl/exibe_sequencia_contador_tempo.sv | 32 +++
 rtl/exibe_sequencia.sv | 106 ++++++++++
 tb/tb_exibe_sequencia.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exibe_sequencia_pkg.sv
// exibe_sequencia: shared state encodings and timer sizing.
// Build option: EXIBE_DEBUG_EN exposes state/timer debug outputs.
package exibe_sequencia_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    PROXIMO = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam int ON_CYCLES_PADRAO  = 4;
  localparam int OFF_CYCLES_PADRAO = 2;

  function automatic int tempo_w(input int on_c, input int off_c);
    return $clog2(on_c > off_c ? on_c : off_c) + 1;
  endfunction

  localparam int TEMPO_W =
    tempo_w(ON_CYCLES_PADRAO, OFF_CYCLES_PADRAO);

endpackage

// File: rtl/exibe_sequencia_if.sv
// exibe_sequencia: request, memory and LED bundle.
// Build option: EXIBE_DEBUG_EN (debug ports live on the top).
interface exibe_sequencia_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              cancela;
  logic [ADDR_W-1:0] limite;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              fim;

  modport master (
    output iniciar, cancela, limite, mem_data,
    input  mem_addr, leds, ocupado, fim
  );

  modport slave (
    input  iniciar, cancela, limite, mem_data,
    output mem_addr, leds, ocupado, fim
  );
endinterface

// File: rtl/exibe_sequencia_contador_tempo.sv
// contador_tempo: loadable down-counter for ON/OFF periods.
// Build option: EXIBE_DEBUG_EN exposes the count value.
module contador_tempo #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] valor,
`ifdef EXIBE_DEBUG_EN
  output logic [W-1:0] tempo,
`endif
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (load)
      cnt <= valor;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  // zero flags the final cycle of the loaded period
  assign zero = (cnt <= W'(1));

`ifdef EXIBE_DEBUG_EN
  assign tempo = cnt;
`endif
endmodule

// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays the stored sequence 0..limite on the LEDs.
// Build option: EXIBE_DEBUG_EN adds db_estado / db_tempo outputs.
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = ON_CYCLES_PADRAO,
  parameter int OFF_CYCLES = OFF_CYCLES_PADRAO
) (
  input logic clock,
  input logic reset_n,
  exibe_sequencia_if.slave bus
`ifdef EXIBE_DEBUG_EN
  ,
  output logic [3:0] db_estado,
  output logic [tempo_w(ON_CYCLES, OFF_CYCLES)-1:0] db_tempo
`endif
);
  localparam int TW = tempo_w(ON_CYCLES, OFF_CYCLES);

  estado_t           estado, estado_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] lim, lim_n;
  logic [DATA_W-1:0] leds, leds_n;
  logic              carga;
  logic [TW-1:0]     valor;
  logic              zero;

  contador_tempo #(.W(TW)) u_tempo (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (carga),
    .valor   (valor),
`ifdef EXIBE_DEBUG_EN
    .tempo   (db_tempo),
`endif
    .zero    (zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado <= OCIOSO;
      addr   <= '0;
      lim    <= '0;
      leds   <= '0;
    end else begin
      estado <= estado_n;
      addr   <= addr_n;
      lim    <= lim_n;
      leds   <= leds_n;
    end
  end

  always_comb begin
    estado_n = estado;
    addr_n   = addr;
    lim_n    = lim;
    leds_n   = leds;
    carga    = 1'b0;
    valor    = '0;
    if (bus.cancela) begin
      estado_n = OCIOSO;
      addr_n   = '0;
      leds_n   = '0;
    end else begin
      unique case (estado)
        OCIOSO: if (bus.iniciar) begin
          estado_n = CARREGA;
          addr_n   = '0;
          lim_n    = bus.limite;
        end
        CARREGA: begin
          leds_n   = bus.mem_data;
          carga    = 1'b1;
          valor    = TW'(ON_CYCLES);
          estado_n = ACENDE;
        end
        ACENDE: if (zero) begin
          leds_n   = '0;
          carga    = 1'b1;
          valor    = TW'(OFF_CYCLES);
          estado_n = APAGA;
        end
        APAGA: if (zero)
          estado_n = (addr == lim) ? FIM : PROXIMO;
        PROXIMO: begin
          addr_n   = addr + 1'b1;
          estado_n = CARREGA;
        end
        FIM:     estado_n = OCIOSO;
        default: estado_n = OCIOSO;
      endcase
    end
  end

  assign bus.mem_addr = addr;
  assign bus.leds     = leds;
  assign bus.ocupado  = (estado != OCIOSO);
  // an abort landing on the FIM cycle suppresses the pulse
  assign bus.fim      = (estado == FIM) && !bus.cancela;

`ifdef EXIBE_DEBUG_EN
  assign db_estado = {1'b0, estado};
`endif
endmodule

// File: tb/tb_exibe_sequencia.sv
// tb_exibe_sequencia: directed checks of the sequence presenter.
// Build option: EXIBE_DEBUG_EN connects the debug ports.
module tb_exibe_sequencia;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  exibe_sequencia_if #(.ADDR_W(4), .DATA_W(4)) bus ();
  exibe_sequencia_if #(.ADDR_W(2), .DATA_W(4)) bus2 ();

  logic [3:0] mem  [16];
  logic [3:0] mem2 [4];

  assign bus.mem_data  = mem[bus.mem_addr];
  assign bus2.mem_data = mem2[bus2.mem_addr];

`ifdef EXIBE_DEBUG_EN
  logic [3:0] db_estado, db_estado2;
  logic [2:0] db_tempo, db_tempo2;
`endif

  exibe_sequencia #(
    .ADDR_W(4), .DATA_W(4), .ON_CYCLES(4), .OFF_CYCLES(2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
`ifdef EXIBE_DEBUG_EN
    .db_estado (db_estado),
    .db_tempo  (db_tempo),
`endif
    .bus     (bus.slave)
  );

  exibe_sequencia #(
    .ADDR_W(2), .DATA_W(4), .ON_CYCLES(4), .OFF_CYCLES(2)
  ) dut2 (
    .clock   (clock),
    .reset_n (reset_n),
`ifdef EXIBE_DEBUG_EN
    .db_estado (db_estado2),
    .db_tempo  (db_tempo2),
`endif
    .bus     (bus2.slave)
  );

  int checks = 0;
  int failures = 0;

  // element index lit in cycle k (8 cycles per element), -1 when dark
  function automatic int idx(input int k);
    int p;
    if (k < 1) return -1;
    p = (k - 1) % 8;
    if (p >= 1 && p <= 4) return (k - 1) / 8;
    return -1;
  endfunction

  // called on a negedge: that cycle is cycle 0, returns at cycle 1
  task automatic start1(input logic [3:0] lim);
    bus.limite  = lim;
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (bus.leds !== 4'h0 || bus.mem_addr !== 4'h0 ||
        bus.ocupado !== 1'b0 || bus.fim !== 1'b0) begin
      failures++;
      $display("FAIL reset got leds=%h addr=%h oc=%b fim=%b exp 0",
               bus.leds, bus.mem_addr, bus.ocupado, bus.fim);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.ocupado !== 1'b0 || bus2.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got oc=%b oc2=%b exp 0",
               bus.ocupado, bus2.ocupado);
    end
  endtask

  task automatic test_tres();
    logic [3:0] el;
    int e;
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h8;
    start1(4'd2);
    for (int k = 1; k <= 26; k++) begin
      e  = idx(k);
      el = (e >= 0 && e <= 2) ? mem[e] : 4'h0;
      checks++;
      if (bus.leds !== el) begin
        failures++;
        $display("FAIL tres_leds k=%0d got=%h exp=%h", k, bus.leds, el);
      end
      checks++;
      if (bus.fim !== (k == 24)) begin
        failures++;
        $display("FAIL tres_fim k=%0d got=%b exp=%b", k, bus.fim, k == 24);
      end
      checks++;
      if (bus.ocupado !== (k <= 24)) begin
        failures++;
        $display("FAIL tres_oc k=%0d got=%b exp=%b", k, bus.ocupado, k <= 24);
      end
      @(negedge clock);
    end
    checks++;
    if (bus.mem_addr !== 4'd2) begin
      failures++;
      $display("FAIL tres_addr_final got=%h exp=2", bus.mem_addr);
    end
  endtask

  task automatic test_limite0();
    logic [3:0] el;
    mem[0] = 4'h8;
    start1(4'd0);
    for (int k = 1; k <= 10; k++) begin
      el = (k >= 2 && k <= 5) ? 4'h8 : 4'h0;
      checks++;
      if (bus.leds !== el || bus.fim !== (k == 8) ||
          bus.ocupado !== (k <= 8)) begin
        failures++;
        $display("FAIL lim0 k=%0d got leds=%h fim=%b oc=%b exp %h %b %b",
                 k, bus.leds, bus.fim, bus.ocupado, el, k == 8, k <= 8);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] el;
    mem[0] = 4'h8;
    mem[1] = 4'h3;
    start1(4'd0);
    repeat (7) @(negedge clock);
    checks++;
    if (bus.fim !== 1'b1) begin
      failures++;
      $display("FAIL b2b_fim1 got=%b exp=1", bus.fim);
    end
    @(negedge clock);
    checks++;
    if (bus.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=0", bus.ocupado);
    end
    start1(4'd1);
    for (int k = 1; k <= 17; k++) begin
      el = (k >= 2 && k <= 5) ? 4'h8 :
           (k >= 10 && k <= 13) ? 4'h3 : 4'h0;
      checks++;
      if (bus.leds !== el || bus.fim !== (k == 16)) begin
        failures++;
        $display("FAIL b2b k=%0d got leds=%h fim=%b exp %h %b",
                 k, bus.leds, bus.fim, el, k == 16);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_cancela();
    int nf;
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;
    start1(4'd2);
    repeat (10) @(negedge clock);
    checks++;
    if (bus.leds !== 4'h2) begin
      failures++;
      $display("FAIL canc_pre got=%h exp=2", bus.leds);
    end
    bus.cancela = 1'b1;
    @(negedge clock);
    bus.cancela = 1'b0;
    checks++;
    if (bus.leds !== 4'h0 || bus.ocupado !== 1'b0 ||
        bus.mem_addr !== 4'h0) begin
      failures++;
      $display("FAIL canc_post got leds=%h oc=%b addr=%h exp 0 0 0",
               bus.leds, bus.ocupado, bus.mem_addr);
    end
    nf = 0;
    repeat (30) begin
      if (bus.fim === 1'b1) nf++;
      @(negedge clock);
    end
    checks++;
    if (nf != 0) begin
      failures++;
      $display("FAIL canc_nofim got=%0d exp=0", nf);
    end
    start1(4'd2);
    checks++;
    if (bus.mem_addr !== 4'h0 || bus.ocupado !== 1'b1) begin
      failures++;
      $display("FAIL canc_restart got addr=%h oc=%b exp 0 1",
               bus.mem_addr, bus.ocupado);
    end
    @(negedge clock);
    checks++;
    if (bus.leds !== 4'h1) begin
      failures++;
      $display("FAIL canc_first got=%h exp=1", bus.leds);
    end
    repeat (22) @(negedge clock);
    checks++;
    if (bus.fim !== 1'b1) begin
      failures++;
      $display("FAIL canc_refim got=%b exp=1", bus.fim);
    end
    @(negedge clock);
  endtask

  task automatic test_ignora();
    logic [3:0] el;
    logic [3:0] prev;
    int e, nf, nel;
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;
    mem[3] = 4'h8; mem[4] = 4'h1; mem[5] = 4'h2;
    nf = 0; nel = 0; prev = 4'h0;
    start1(4'd2);
    for (int k = 1; k <= 40; k++) begin
      e  = idx(k);
      el = (e >= 0 && e <= 2) ? mem[e] : 4'h0;
      checks++;
      if (bus.leds !== el || bus.fim !== (k == 24)) begin
        failures++;
        $display("FAIL ign k=%0d got leds=%h fim=%b exp %h %b",
                 k, bus.leds, bus.fim, el, k == 24);
      end
      if (bus.fim === 1'b1) nf++;
      if (prev == 4'h0 && bus.leds != 4'h0) nel++;
      prev = bus.leds;
      if (k == 5) begin
        bus.iniciar = 1'b1;
        bus.limite  = 4'd5;
      end
      if (k == 6) bus.iniciar = 1'b0;
      @(negedge clock);
    end
    checks++;
    if (nf != 1 || nel != 3) begin
      failures++;
      $display("FAIL ign_counts got fim=%0d elem=%0d exp 1 3", nf, nel);
    end
  endtask

  task automatic test_reset_mid();
    int busy;
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;
    start1(4'd2);
    repeat (13) @(negedge clock);
    checks++;
    if (bus.mem_addr !== 4'h1 || bus.ocupado !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre got addr=%h oc=%b exp 1 1",
               bus.mem_addr, bus.ocupado);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.leds !== 4'h0 || bus.mem_addr !== 4'h0 ||
        bus.ocupado !== 1'b0 || bus.fim !== 1'b0) begin
      failures++;
      $display("FAIL rmid_apaga got leds=%h addr=%h oc=%b fim=%b exp 0",
               bus.leds, bus.mem_addr, bus.ocupado, bus.fim);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start1(4'd2);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.leds !== 4'h0 || bus.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL rmid_acende got leds=%h oc=%b exp 0 0",
               bus.leds, bus.ocupado);
    end
    @(negedge clock);
    reset_n = 1'b1;
    busy = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.ocupado !== 1'b0 || bus.leds !== 4'h0) busy++;
    end
    checks++;
    if (busy != 0) begin
      failures++;
      $display("FAIL rmid_idle got=%0d busy cycles exp=0", busy);
    end
  endtask

  task automatic test_addr2();
    logic [3:0] el;
    int e;
    mem2[0] = 4'h1; mem2[1] = 4'h2; mem2[2] = 4'h4; mem2[3] = 4'h8;
    bus2.limite  = 2'd3;
    bus2.iniciar = 1'b1;
    @(negedge clock);
    bus2.iniciar = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      e  = idx(k);
      el = (e >= 0 && e <= 3) ? mem2[e] : 4'h0;
      checks++;
      if (bus2.leds !== el || bus2.fim !== (k == 32) ||
          bus2.ocupado !== (k <= 32)) begin
        failures++;
        $display("FAIL addr2 k=%0d got leds=%h fim=%b oc=%b exp %h %b %b",
                 k, bus2.leds, bus2.fim, bus2.ocupado, el,
                 k == 32, k <= 32);
      end
      @(negedge clock);
    end
    checks++;
    if (bus2.mem_addr !== 2'd3) begin
      failures++;
      $display("FAIL addr2_final got=%h exp=3", bus2.mem_addr);
    end
  endtask

  initial begin
    bus.iniciar  = 1'b0;
    bus.cancela  = 1'b0;
    bus.limite   = '0;
    bus2.iniciar = 1'b0;
    bus2.cancela = 1'b0;
    bus2.limite  = '0;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    for (int i = 0; i < 4; i++) mem2[i] = 4'h0;
    test_reset();
    test_tres();
    test_limite0();
    test_back_to_back();
    test_cancela();
    test_ignora();
    test_reset_mid();
    test_addr2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
